// File: rtl/led_sequencer.sv
// LED pattern sequencer: a prescaler turns the clock into a display tick,
// and each tick steps a WIDTH-bit pattern by the selected mode.
//
// Ports:
//   clock       system clock, rising edge
//   clear_n     synchronous active-low reset
//   count       prescaler enable; low freezes divider and pattern
//   mode        00 rotate-left, 01 rotate-right, 10 bounce, 11 count up
//   load        synchronous pattern load strobe
//   load_value  pattern written on load
//   Q           current pattern (registered)
//   tick        high for the cycle after each prescaler step
module led_sequencer #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      CYCLES_PER_TICK = 12000000,
    parameter int unsigned      DIV_WIDTH       = 24,
    parameter logic [WIDTH-1:0] INIT_PATTERN    = WIDTH'(8'b00010001)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             count,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             tick
);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [DIV_WIDTH-1:0] DIV_LAST =
        DIV_WIDTH'(CYCLES_PER_TICK - 1);

    logic [WIDTH-1:0]     q_q;
    logic                 tick_q;
    logic [DIV_WIDTH-1:0] div_q;
    dir_e                 dir_q;

    logic [WIDTH-1:0]     step_q_d;
    dir_e                 step_dir_d;

    // Pattern and direction that a step on this edge would produce.
    always_comb begin
        step_q_d   = q_q;
        step_dir_d = dir_q;
        unique case (mode)
            2'b00: step_q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            2'b01: step_q_d = {q_q[0], q_q[WIDTH-1:1]};
            2'b10: begin
                if (q_q == '0) begin
                    // an empty bounce pattern restarts from bit 0
                    step_q_d   = WIDTH'(1);
                    step_dir_d = DIR_LEFT;
                end else if (dir_q == DIR_LEFT && q_q[WIDTH-1]) begin
                    step_q_d   = q_q >> 1;
                    step_dir_d = DIR_RIGHT;
                end else if (dir_q == DIR_RIGHT && q_q[0]) begin
                    step_q_d   = q_q << 1;
                    step_dir_d = DIR_LEFT;
                end else if (dir_q == DIR_LEFT) begin
                    step_q_d   = q_q << 1;
                end else begin
                    step_q_d   = q_q >> 1;
                end
            end
            2'b11: step_q_d = q_q + WIDTH'(1);
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            q_q    <= INIT_PATTERN;
            div_q  <= '0;
            dir_q  <= DIR_LEFT;
            tick_q <= 1'b0;
        end else if (load) begin
            q_q    <= load_value;
            div_q  <= '0;
            dir_q  <= DIR_LEFT;
            tick_q <= 1'b0;
        end else if (count) begin
            if (div_q == DIV_LAST) begin
                div_q  <= '0;
                q_q    <= step_q_d;
                dir_q  <= step_dir_d;
                tick_q <= 1'b1;
            end else begin
                div_q  <= div_q + DIV_WIDTH'(1);
                tick_q <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign Q    = q_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed table, corner sequences
// and a randomized run against a behavioural model of three configurations.
module tb_led_sequencer;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       count = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;

    logic [7:0] q4, q1, q2;
    logic       t4, t1, t2;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    led_sequencer #(.WIDTH(8), .CYCLES_PER_TICK(4)) dut4 (
        .clock(clock), .clear_n(clear_n), .count(count), .mode(mode),
        .load(load), .load_value(load_value), .Q(q4), .tick(t4));

    led_sequencer #(.WIDTH(8), .CYCLES_PER_TICK(1)) dut1 (
        .clock(clock), .clear_n(clear_n), .count(count), .mode(mode),
        .load(load), .load_value(load_value), .Q(q1), .tick(t1));

    led_sequencer #(.WIDTH(8), .CYCLES_PER_TICK(2)) dut2 (
        .clock(clock), .clear_n(clear_n), .count(count), .mode(mode),
        .load(load), .load_value(load_value), .Q(q2), .tick(t2));

    // Behavioural model: pattern as an integer, enabled-cycle count since
    // the last reset/load, and a "moving left" flag for bounce.
    int cpt[3] = '{4, 1, 2};
    int mq[3];
    int mn[3];
    bit ml[3];
    bit mt[3];

    function automatic void model_step(int k);
        int v;
        v = mq[k];
        case (mode)
            2'd0: v = ((v * 2) % 256) + (v / 128);
            2'd1: v = (v / 2) + ((v % 2) * 128);
            2'd2: begin
                if (v == 0) begin
                    v = 1;
                    ml[k] = 1'b1;
                end else if (ml[k] && v >= 128) begin
                    ml[k] = 1'b0;
                    v = v / 2;
                end else if (!ml[k] && (v % 2) == 1) begin
                    ml[k] = 1'b1;
                    v = (v * 2) % 256;
                end else if (ml[k]) begin
                    v = (v * 2) % 256;
                end else begin
                    v = v / 2;
                end
            end
            default: v = (v + 1) % 256;
        endcase
        mq[k] = v;
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 3; k++) begin
            mt[k] = 1'b0;
            if (!clear_n) begin
                mq[k] = 'h11;
                mn[k] = 0;
                ml[k] = 1'b1;
            end else if (load) begin
                mq[k] = int'(load_value);
                mn[k] = 0;
                ml[k] = 1'b1;
            end else if (count) begin
                mn[k] = mn[k] + 1;
                if (mn[k] == cpt[k]) begin
                    mn[k] = 0;
                    mt[k] = 1'b1;
                    model_step(k);
                end
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
        model_edge();
    endtask

    task automatic check(string name, int idx, logic [7:0] aq, logic at,
                         logic [7:0] eq, logic et);
        vectors++;
        if (aq !== eq || at !== et) begin
            errors++;
            $display("FAIL %s[%0d]: Q=%h tick=%b, expected Q=%h tick=%b",
                     name, idx, aq, at, eq, et);
        end
    endtask

    typedef struct {
        bit       rn;
        bit       cnt;
        bit [1:0] md;
        bit       ld;
        bit [7:0] lv;
        bit [7:0] eq;
        bit       et;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rn, bit cnt, bit [1:0] md, bit ld,
                                bit [7:0] lv, bit [7:0] eq, bit et);
        vec_t v;
        v.rn = rn; v.cnt = cnt; v.md = md; v.ld = ld;
        v.lv = lv; v.eq = eq; v.et = et;
        tbl.push_back(v);
    endfunction

    function automatic void add_hold(int n, bit cnt, bit [1:0] md,
                                     bit [7:0] eq);
        for (int i = 0; i < n; i++) add(1, cnt, md, 0, 8'h00, eq, 0);
    endfunction

    initial begin
        bit [7:0] rl[5];
        bit [7:0] e;
        rl = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h11};

        // rotate-left, CYCLES_PER_TICK=4
        add(0, 0, 2'd0, 0, 8'h00, 8'h11, 0);
        for (int i = 0; i < 4; i++) begin
            add_hold(3, 1, 2'd0, rl[i]);
            add(1, 1, 2'd0, 0, 8'h00, rl[i+1], 1);
        end
        // rotate-right, then pause with divider at 2
        add_hold(3, 1, 2'd1, 8'h11);
        add(1, 1, 2'd1, 0, 8'h00, 8'h88, 1);
        add_hold(3, 1, 2'd1, 8'h88);
        add(1, 1, 2'd1, 0, 8'h00, 8'h44, 1);
        add_hold(2, 1, 2'd1, 8'h44);
        add_hold(10, 0, 2'd1, 8'h44);
        add_hold(1, 1, 2'd1, 8'h44);
        add(1, 1, 2'd1, 0, 8'h00, 8'h22, 1);
        // load on a step edge wins
        add_hold(3, 1, 2'd1, 8'h22);
        add(1, 1, 2'd1, 1, 8'h5A, 8'h5A, 0);
        // mode switch mid-period keeps the phase
        add_hold(1, 1, 2'd0, 8'h5A);
        add_hold(2, 1, 2'd1, 8'h5A);
        add(1, 1, 2'd1, 0, 8'h00, 8'h2D, 1);
        // reset together with load, then first step 4 edges later
        add_hold(2, 1, 2'd0, 8'h2D);
        add(0, 1, 2'd0, 1, 8'hFF, 8'h11, 0);
        add_hold(3, 1, 2'd0, 8'h11);
        add(1, 1, 2'd0, 0, 8'h00, 8'h22, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            clear_n = tbl[i].rn;
            count = tbl[i].cnt;
            mode = tbl[i].md;
            load = tbl[i].ld;
            load_value = tbl[i].lv;
            cyc();
            check("table", i, q4, t4, tbl[i].eq, tbl[i].et);
        end

        // bounce on the CYCLES_PER_TICK=1 instance
        clear_n = 1; count = 1; mode = 2'd2; load = 1; load_value = 8'h01;
        cyc();
        check("bounce_load", 0, q1, t1, 8'h01, 0);
        load = 0;
        for (int i = 1; i <= 7; i++) begin
            e = 8'h01 << i;
            cyc();
            check("bounce_up", i, q1, t1, e, 1);
        end
        for (int i = 6; i >= 0; i--) begin
            e = 8'h01 << i;
            cyc();
            check("bounce_down", i, q1, t1, e, 1);
        end
        cyc();
        check("bounce_turn", 0, q1, t1, 8'h02, 1);
        load = 1; load_value = 8'h00;
        cyc();
        check("bounce_zero", 0, q1, t1, 8'h00, 0);
        load = 0;
        cyc();
        check("bounce_recover", 0, q1, t1, 8'h01, 1);

        // binary wrap on the CYCLES_PER_TICK=2 instance
        mode = 2'd3; load = 1; load_value = 8'hFE;
        cyc();
        check("bin_load", 0, q2, t2, 8'hFE, 0);
        load = 0;
        cyc();
        check("bin", 1, q2, t2, 8'hFE, 0);
        cyc();
        check("bin", 2, q2, t2, 8'hFF, 1);
        cyc();
        check("bin", 3, q2, t2, 8'hFF, 0);
        cyc();
        check("bin", 4, q2, t2, 8'h00, 1);

        // randomized run against the model, all three instances
        clear_n = 0; load = 0;
        cyc();
        for (int i = 0; i < 3000; i++) begin
            clear_n = ($urandom % 64) != 0;
            count = ($urandom % 4) != 0;
            mode = 2'($urandom);
            load = ($urandom % 16) == 0;
            load_value = 8'($urandom);
            cyc();
            check("rand_cpt4", i, q4, t4, 8'(mq[0]), mt[0]);
            check("rand_cpt1", i, q1, t1, 8'(mq[1]), mt[1]);
            check("rand_cpt2", i, q2, t2, 8'(mq[2]), mt[2]);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
